// File: rtl/ps2_scan_receiver_if.sv
// ============================================================================
// Module  : ps2_scan_receiver_if
// Brief   : PS/2 line inputs and decoded scan-code outputs of the receiver.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ps2_scan_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       make_strobe;
    logic       break_strobe;
    logic [7:0] break_code;
    logic       frame_error;

    modport slave (
        input  ps2_clk, ps2_data,
        output scan_code, make_strobe, break_strobe, break_code, frame_error
    );

    modport master (
        output ps2_clk, ps2_data,
        input  scan_code, make_strobe, break_strobe, break_code, frame_error
    );
endinterface

`default_nettype wire

// File: rtl/ps2_scan_receiver.sv
// ============================================================================
// Module  : ps2_scan_receiver
// Brief   : PS/2 keyboard frame receiver with F0/E0 prefix filtering.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_scan_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    ps2_scan_receiver_if.slave bus
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] C_FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] C_FILT_ONE = FW'(1);
    localparam logic [TW-1:0] C_TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] C_TO_ONE   = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic          clk_s0_q, clk_s1_q, dat_s0_q, dat_s1_q;
    logic          filt_q, filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic          w_fall;

    // Synchronizers and clock glitch filter idle high, matching the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s0_q    <= 1'b1;
            clk_s1_q    <= 1'b1;
            dat_s0_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_s0_q    <= bus.ps2_clk;
            clk_s1_q    <= clk_s0_q;
            dat_s0_q    <= bus.ps2_data;
            dat_s1_q    <= dat_s0_q;
            filt_prev_q <= filt_q;
            if (clk_s1_q == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == C_FILT_MAX) begin
                filt_q     <= clk_s1_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + C_FILT_ONE;
            end
        end
    end

    assign w_fall = filt_prev_q & ~filt_q;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          break_pending_q, break_pending_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic [7:0]    break_code_q, break_code_d;
    logic          make_q, make_d;
    logic          brk_q, brk_d;
    logic          err_q, err_d;
    logic          w_parity_ok;

    assign w_parity_ok = ^{shift_q, par_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            par_q           <= 1'b0;
            to_cnt_q        <= '0;
            break_pending_q <= 1'b0;
            scan_code_q     <= '0;
            break_code_q    <= '0;
            make_q          <= 1'b0;
            brk_q           <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            par_q           <= par_d;
            to_cnt_q        <= to_cnt_d;
            break_pending_q <= break_pending_d;
            scan_code_q     <= scan_code_d;
            break_code_q    <= break_code_d;
            make_q          <= make_d;
            brk_q           <= brk_d;
            err_q           <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        par_d           = par_q;
        to_cnt_d        = to_cnt_q;
        break_pending_d = break_pending_q;
        scan_code_d     = scan_code_q;
        break_code_d    = break_code_q;
        make_d          = 1'b0;
        brk_d           = 1'b0;
        err_d           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_fall && !dat_s1_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    shift_d   = {dat_s1_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    par_d   = dat_s1_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    state_d = S_IDLE;
                    if (dat_s1_q && w_parity_ok) begin
                        if (shift_q == 8'hF0) begin
                            break_pending_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            break_pending_d = break_pending_q;
                        end else if (break_pending_q) begin
                            break_code_d    = shift_q;
                            brk_d           = 1'b1;
                            break_pending_d = 1'b0;
                        end else begin
                            scan_code_d = shift_q;
                            make_d      = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Only a frame in progress can time out; a falling edge restarts the wait.
        if (state_q == S_IDLE) begin
            to_cnt_d = '0;
        end else if (w_fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == C_TO_MAX) begin
            to_cnt_d = '0;
            state_d  = S_IDLE;
            err_d    = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + C_TO_ONE;
        end
    end

    assign bus.scan_code    = scan_code_q;
    assign bus.break_code   = break_code_q;
    assign bus.make_strobe  = make_q;
    assign bus.break_strobe = brk_q;
    assign bus.frame_error  = err_q;

endmodule

`default_nettype wire

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Front-end PS/2 keyboard receiver: samples the keyboard's ps2_clk/ps2_data lines, deframes 11-bit frames and checks parity and stop bit.
- Filters break (0xF0) and extended (0xE0) prefixes.
- Presents the last make code as a held 8-bit scan code; this directly feeds the scan-code-to-select translator that maps T/B/M/A keys.
- Also emits single-cycle make/break/error strobes for control logic.

Parameters:
- FILTER_LEN, 8, number of consecutive identical synchronized samples required before the filtered ps2_clk changes state.
- TIMEOUT_CYCLES, 50000, clk cycles with no filtered ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
- ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
- scan_code  output  8  last accepted make code, held until the next make code.
- make_strobe  output  1  1-cycle pulse: scan_code was just updated with a new make code.
- break_strobe  output  1  1-cycle pulse: a key release (F0 xx) completed.
- break_code  output  8  code byte of the last release, held.
- frame_error  output  1  1-cycle pulse: parity error, stop error, or timeout.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All outputs 0; scan_code = 0x00, break_code = 0x00.
  - FSM in IDLE; break_pending = 0; counters 0; filter state = 1 (bus idle high).
- Input conditioning:
  - Both inputs pass through a 2-FF synchronizer.
  - ps2_clk then passes the FILTER_LEN glitch filter.
  - A falling edge is defined as the filtered value going 1→0 between consecutive clk cycles.
  - ps2_data (synchronized) is sampled on the same cycle the falling edge is detected.
- FSM, advancing only on falling edges except for timeout:
  - IDLE: sampled data=0 (start bit) → DATA, bit_cnt=0. Sampled data=1 → stay IDLE, no error.
  - DATA: shift into byte LSB-first; after the 8th bit → PARITY.
  - PARITY: capture the bit. Odd parity is required: the ones count over data+parity must be odd.
  - STOP: stop bit must be 1.
    - Stop ok and parity ok → byte accepted, return to IDLE.
    - Otherwise → frame_error pulse, byte discarded, return to IDLE.
- Timeout:
  - In any state other than IDLE, the counter increments each clk cycle and clears on every falling edge.
  - On reaching TIMEOUT_CYCLES → IDLE, frame_error pulse, partial byte discarded, break_pending unchanged.
  - Counter held at 0 in IDLE.
- Accepted byte handling, outputs registered one clk after the STOP falling edge is detected:
  - 0xF0: break_pending=1; no strobe.
  - 0xE0: discarded silently; no strobe; break_pending unchanged.
  - Other byte with break_pending=1: break_code=byte, break_strobe=1, break_pending=0, scan_code unchanged.
  - Other byte with break_pending=0: scan_code=byte, make_strobe=1.
  - Typematic repeats of the same make code re-pulse make_strobe, with the same scan_code.
- Strobe rules:
  - All strobes are high for exactly one clk cycle.
  - make_strobe and break_strobe are never asserted together.
  - frame_error is never asserted together with make_strobe or break_strobe.
- A parity or stop error on a byte following F0 leaves break_pending=1; the next good byte is treated as the release.
- Reset asserted mid-frame aborts immediately, with the full reset state above. After reset_n releases, the receiver resynchronizes on the next start bit.
- Host-to-device transmission is not supported; the lines are input-only.

Test Plan:
- Good frame 0x2C (bits 0,0,0,1,1,0,1,0,0, parity 0, stop 1) at 10 kHz PS/2 clock → scan_code=0x2C, one make_strobe pulse, frame_error=0.
- Sequence 0x3A, then F0, then 0x3A (parity 1, 1, 1) → make_strobe once with scan_code=0x3A; after the F0 frame no strobe; after the final 0x3A frame break_strobe pulses, break_code=0x3A, scan_code still 0x3A.
- 0x32 sent with parity bit flipped to 1 → frame_error pulse, scan_code keeps its prior value, no make_strobe; a following good 0x1C → scan_code=0x1C.
- E0 then 0x1C → no strobe on E0; make_strobe with scan_code=0x1C after the second frame.
- Stop after 5 data bits (ps2_clk held high) → frame_error exactly TIMEOUT_CYCLES clk after the last falling edge; a subsequent full 0x2C frame decodes correctly.
- 1-clk-wide glitches on ps2_clk (shorter than FILTER_LEN) during a 0x32 frame → ignored, scan_code=0x32. reset_n pulsed low mid-frame → all outputs 0 immediately, no strobe from the truncated frame.
